// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding.
// Captures decoded operands and control, then presents ALU operands
// (SrcA/SrcB), the ALU code and the store-data value (ex_rs2).
// Optional feature: define ID_EX_FORWARDING_EN to compile in EX/MEM and
// MEM/WB forwarding onto both source operands. Without it the registered
// register-file values are used directly and the later-stage inputs are unused.

`ifdef ID_EX_FORWARDING_EN
// Per-operand forwarding selector; EX/MEM is the younger result and wins.
module id_ex_fwd #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     src_data,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd
);
  // x0 is hardwired zero, so a later stage claiming to write it is ignored
  always_comb begin
    fwd = src_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_addr))
      fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_addr))
      fwd = memwb_result;
  end
endmodule
`endif

module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      alu_src,
  input  logic [OPCODE_LENGTH-1:0]  alu_op,
  input  logic                      reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      exmem_reg_write,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic [DATA_WIDTH-1:0]     ex_rs2
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      alu_src;
    logic [OPCODE_LENGTH-1:0]  alu_op;
    logic                      reg_write;
  } stage_t;

  stage_t dec, ex_q;

  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0] src_addr;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     src_data;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     fwd;

  // Pack the decode inputs; a non-valid slot can never write back
  always_comb begin
    dec           = '0;
    dec.valid     = in_valid;
    dec.rs1_data  = rs1_data;
    dec.rs2_data  = rs2_data;
    dec.imm       = imm;
    dec.rs1       = rs1_addr;
    dec.rs2       = rs2_addr;
    dec.rd        = rd_addr;
    dec.alu_src   = alu_src;
    dec.alu_op    = alu_op;
    dec.reg_write = reg_write & in_valid;
  end

  // Stage register: flush beats stall, all-zero bubble is a valid-less ADD
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ex_q <= '0;
    else if (flush)  ex_q <= '0;
    else if (!stall) ex_q <= dec;
  end

  assign src_addr[0] = ex_q.rs1;
  assign src_addr[1] = ex_q.rs2;
  assign src_data[0] = ex_q.rs1_data;
  assign src_data[1] = ex_q.rs2_data;

`ifdef ID_EX_FORWARDING_EN
  // Forwarding is purely combinational, so held operands follow later stages
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    id_ex_fwd #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd (
      .src_addr       (src_addr[g]),
      .src_data       (src_data[g]),
      .exmem_rd       (exmem_rd),
      .exmem_reg_write(exmem_reg_write),
      .exmem_result   (exmem_result),
      .memwb_rd       (memwb_rd),
      .memwb_reg_write(memwb_reg_write),
      .memwb_result   (memwb_result),
      .fwd            (fwd[g])
    );
  end
`else
  logic unused_fwd;
  assign fwd        = src_data;
  assign unused_fwd = ^{src_addr, exmem_rd, exmem_reg_write, exmem_result,
                        memwb_rd, memwb_reg_write, memwb_result};
`endif

  assign SrcA         = fwd[0];
  assign SrcB         = ex_q.alu_src ? ex_q.imm : fwd[1];
  assign ex_rs2       = fwd[1];
  assign Operation    = ex_q.alu_op;
  assign ex_valid     = ex_q.valid;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with an expected-output scoreboard.
// Expected values come from a bench-side stage model; forwarding checks
// adapt to whether ID_EX_FORWARDING_EN is defined for the build.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int OL = 4;
  localparam int RW = 5;
`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, stall, flush;
  logic [DW-1:0] rs1_data, rs2_data, imm;
  logic [RW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic          alu_src;
  logic [OL-1:0] alu_op;
  logic          reg_write;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic          exmem_reg_write, memwb_reg_write;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] SrcA, SrcB, ex_rs2;
  logic [OL-1:0] Operation;
  logic          ex_valid;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;

  id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_rs2(ex_rs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [DW-1:0] rs1d, rs2d, imm;
    logic [RW-1:0] rs1, rs2, rd;
    logic          alu_src;
    logic [OL-1:0] op;
    logic          rw;
  } model_t;

  typedef struct {
    logic [DW-1:0] srca, srcb, rs2;
    logic [OL-1:0] op;
    logic          valid;
    logic [RW-1:0] rd;
    logic          rw;
  } exp_t;

  model_t m;
  exp_t   exp_q[$];
  int     total = 0;
  int     bad   = 0;

  function automatic model_t bubble();
    model_t b;
    b.valid = 0; b.rs1d = '0; b.rs2d = '0; b.imm = '0;
    b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.alu_src = 0; b.op = '0; b.rw = 0;
    return b;
  endfunction

  function automatic logic [DW-1:0] fwd_m(input logic [RW-1:0] a, input logic [DW-1:0] d);
    if (FWD_EN && exmem_reg_write && exmem_rd != 0 && exmem_rd == a) return exmem_result;
    if (FWD_EN && memwb_reg_write && memwb_rd != 0 && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.srca  = fwd_m(m.rs1, m.rs1d);
    e.rs2   = fwd_m(m.rs2, m.rs2d);
    e.srcb  = m.alu_src ? m.imm : e.rs2;
    e.op    = m.op;
    e.valid = m.valid;
    e.rd    = m.rd;
    e.rw    = m.rw;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".SrcA"}, SrcA, e.srca);
    chk({tag, ".SrcB"}, SrcB, e.srcb);
    chk({tag, ".ex_rs2"}, ex_rs2, e.rs2);
    chk({tag, ".Operation"}, DW'(Operation), DW'(e.op));
    chk({tag, ".ex_valid"}, DW'(ex_valid), DW'(e.valid));
    chk({tag, ".ex_rd"}, DW'(ex_rd), DW'(e.rd));
    chk({tag, ".ex_reg_write"}, DW'(ex_reg_write), DW'(e.rw));
  endtask

  // Advance the model by one edge, push the expectation, clock, then compare
  task automatic step(input string tag);
    if (flush) m = bubble();
    else if (!stall) begin
      m.valid = in_valid; m.rs1d = rs1_data; m.rs2d = rs2_data; m.imm = imm;
      m.rs1 = rs1_addr; m.rs2 = rs2_addr; m.rd = rd_addr; m.alu_src = alu_src;
      m.op = alu_op; m.rw = reg_write & in_valid;
    end
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    compare(tag);
  endtask

  // Combinational check of the current state against current inputs
  task automatic check_now(input string tag);
    exp_q.push_back(model_out());
    #1;
    compare(tag);
  endtask

  task automatic dec(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [RW-1:0] ra, input logic [RW-1:0] rb, input logic [RW-1:0] rd,
                     input logic src, input logic [DW-1:0] im, input logic [OL-1:0] op,
                     input logic we);
    in_valid = v; rs1_data = a; rs2_data = b; rs1_addr = ra; rs2_addr = rb;
    rd_addr = rd; alu_src = src; imm = im; alu_op = op; reg_write = we;
  endtask

  task automatic fwd_in(input logic [RW-1:0] xr, input logic xw, input logic [DW-1:0] xd,
                        input logic [RW-1:0] wr, input logic ww, input logic [DW-1:0] wd);
    exmem_rd = xr; exmem_reg_write = xw; exmem_result = xd;
    memwb_rd = wr; memwb_reg_write = ww; memwb_result = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m = bubble();
    reset = 1; stall = 0; flush = 0;
    dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_in(0, 0, 0, 0, 0, 0);
    #12;
    check_now("reset");
    reset = 0;

    // basic capture
    dec(1, 5, 7, 1, 2, 4, 0, 0, 4'b0001, 1);
    step("capture");
    // invalid slot suppresses reg_write
    dec(0, 9, 9, 1, 2, 6, 0, 0, 4'b0010, 1);
    step("invalid_rw");

    // forwarding priority on rs1=3
    dec(1, 32'h11, 32'h22, 3, 5, 7, 0, 0, 4'b0011, 1);
    step("fwd_cap");
    fwd_in(3, 1, 32'hAA, 3, 1, 32'hBB);
    check_now("fwd_exmem");
    fwd_in(3, 0, 32'hAA, 3, 1, 32'hBB);
    check_now("fwd_memwb");
    fwd_in(0, 0, 0, 0, 0, 0);
    check_now("fwd_none");

    // x0 guard
    dec(1, 32'h1, 32'h0, 1, 0, 2, 0, 0, 4'b0100, 1);
    step("x0_cap");
    fwd_in(0, 1, 32'hFF, 0, 1, 32'hEE);
    check_now("x0_guard");
    fwd_in(0, 0, 0, 0, 0, 0);

    // immediate select with rs2 forward match
    dec(1, 32'h3, 32'h22, 1, 6, 8, 1, 32'hFFFFFFFC, 4'b1010, 1);
    step("imm_cap");
    fwd_in(6, 1, 32'h66, 0, 0, 0);
    check_now("imm_sel");
    fwd_in(0, 0, 0, 0, 0, 0);

    // stall holds for two edges while forwarding still tracks
    dec(1, 32'h70, 32'h71, 7, 9, 10, 0, 0, 4'b0010, 1);
    step("stall_cap");
    stall = 1;
    dec(1, 32'h99, 32'h98, 11, 12, 13, 1, 32'h5, 4'b0101, 0);
    step("stall_1");
    step("stall_2");
    fwd_in(7, 1, 32'h77, 9, 1, 32'h79);
    check_now("stall_fwd");
    fwd_in(0, 0, 0, 0, 0, 0);
    // flush beats stall
    flush = 1;
    step("flush");
    stall = 0; flush = 0;

    // asynchronous reset between edges
    dec(1, 32'h44, 32'h45, 14, 15, 16, 0, 0, 4'b0011, 1);
    step("pre_rst");
    #2;
    reset = 1;
    m = bubble();
    check_now("async_rst");
    @(posedge clk); #1;
    check_now("rst_hold");
    reset = 0;
    dec(1, 32'h33, 32'h34, 3, 4, 5, 0, 0, 4'b0110, 1);
    step("post_rst");
    fwd_in(3, 1, 32'hAA, 3, 1, 32'hBB);
    check_now("post_rst_fwd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, operand/result width; OPCODE_LENGTH, 4, ALU operation code width; REG_ADDR_WIDTH, 5, register index width.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous, active-high reset
  in_valid  in  1  decode stage presents a valid instruction
  stall  in  1  hold the current stage contents
  flush  in  1  replace the stage contents with a bubble
  rs1_data, rs2_data  in  DATA_WIDTH  register-file read values
  imm  in  DATA_WIDTH  sign-extended immediate
  rs1_addr, rs2_addr, rd_addr  in  REG_ADDR_WIDTH  source and destination indices
  alu_src  in  1  1 selects imm as the B operand
  alu_op  in  OPCODE_LENGTH  ALU operation code
  reg_write  in  1  instruction writes rd
  exmem_rd, memwb_rd  in  REG_ADDR_WIDTH  destination indices of the later stages
  exmem_reg_write, memwb_reg_write  in  1  later stages write their rd
  exmem_result, memwb_result  in  DATA_WIDTH  results of the later stages
  SrcA, SrcB  out  DATA_WIDTH  ALU operands
  Operation  out  OPCODE_LENGTH  ALU operation code
  ex_valid  out  1  stage holds a valid instruction
  ex_rd  out  REG_ADDR_WIDTH  registered rd
  ex_reg_write  out  1  registered reg_write, gated by valid
  ex_rs2  out  DATA_WIDTH  forwarded rs2 value (store data)

Function
REQ-003 On each rising clk edge without stall or flush, the stage SHALL capture all decode inputs and set ex_valid to in_valid; latency from decode to ALU operands is 1 cycle.
REQ-004 When stall=1 and flush=0, all stage registers SHALL hold their values.
REQ-005 When flush=1, the next edge SHALL load a bubble: ex_valid=0, ex_reg_write=0, Operation=0 (ADD), ex_rd=0, all data registers 0; flush SHALL take priority over stall.
REQ-006 When in_valid=0 is captured, ex_reg_write SHALL be 0 regardless of the reg_write input.
REQ-007 The forwarded A operand (fwdA) SHALL be computed combinationally from the registered rs1 as follows:
  - exmem_result when exmem_reg_write=1, exmem_rd!=0 and exmem_rd equals the registered rs1;
  - otherwise memwb_result when memwb_reg_write=1, memwb_rd!=0 and memwb_rd equals the registered rs1;
  - otherwise the registered rs1_data.
REQ-008 fwdB SHALL be computed like fwdA, but from the registered rs2; EX/MEM SHALL take priority over MEM/WB when both match.
REQ-009 SrcA SHALL equal fwdA; SrcB SHALL equal the registered imm when the registered alu_src=1, otherwise fwdB; ex_rs2 SHALL always equal fwdB.
REQ-010 Register index 0 SHALL never be forwarded, even when a later stage claims to write it.
REQ-011 Operation SHALL be the registered alu_op; codes 0000 to 1010 pass unmodified and no other code is generated internally.
REQ-012 Forwarding SHALL evaluate in the same cycle even while stall=1, so that held operands track later-stage results.

Reset
REQ-013 Asserting reset SHALL immediately clear all stage registers to zero: ex_valid=0, ex_reg_write=0, Operation=0, ex_rd=0.
REQ-014 Reset asserted mid-operation SHALL discard the in-flight instruction; the first capture SHALL occur at the first rising edge after reset deasserts.

Configuration
REQ-015 When the macro ID_EX_FORWARDING_EN is defined, the forwarding behaviour of REQ-007 to REQ-010 SHALL be compiled in.
REQ-016 When ID_EX_FORWARDING_EN is undefined, fwdA and fwdB SHALL equal the registered rs1_data and rs2_data, and the forwarding inputs SHALL be ignored; all other behaviour is unchanged.

Verification
REQ-017 Basic capture: rs1_data=5, rs2_data=7, alu_op=0001, alu_src=0, in_valid=1 -> one edge later SrcA=5, SrcB=7, Operation=0001, ex_valid=1.
REQ-018 Forwarding priority: registered rs1=3, exmem_rd=3 with exmem_result=0xAA, memwb_rd=3 with memwb_result=0xBB, both write enables 1 -> SrcA=0xAA; with exmem_reg_write=0 -> SrcA=0xBB.
REQ-019 x0 guard: rs2=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFF, registered rs2_data=0 -> SrcB=0 and ex_rs2=0.
REQ-020 Stall and flush: stall=1 for 2 cycles -> outputs hold; stall=1 together with flush=1 -> next edge ex_valid=0, ex_reg_write=0, Operation=0.
REQ-021 Immediate select: alu_src=1, imm=0xFFFFFFFC, rs2 forwarding match -> SrcB=0xFFFFFFFC, ex_rs2=forwarded value.
REQ-022 Asynchronous reset: assert reset between edges while ex_valid=1 -> ex_valid=0 and Operation=0 before the next edge; with ID_EX_FORWARDING_EN undefined, repeat REQ-018 -> SrcA=registered rs1_data.
